// File: rtl/dram_port_arbiter_if.sv
// Core-side request/ack bus plus the single-port RAM bus of the shared data-memory arbiter.
// master = cores and RAM model, slave = arbiter.
interface dram_port_arbiter_if #(
  parameter int N_CORES = 4,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16
);
  logic [N_CORES-1:0]        req;
  logic [N_CORES-1:0]        we;
  logic [N_CORES*ADDR_W-1:0] addr;
  logic [N_CORES*DATA_W-1:0] wdata;
  logic [N_CORES-1:0]        ack;
  logic [DATA_W-1:0]         rdata;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_wdata;
  logic                      mem_wren;
  logic [DATA_W-1:0]         mem_q;

  modport master (
    output req, we, addr, wdata, mem_q,
    input  ack, rdata, mem_addr, mem_wdata, mem_wren
  );

  modport slave (
    input  req, we, addr, wdata, mem_q,
    output ack, rdata, mem_addr, mem_wdata, mem_wren
  );
endinterface

// File: rtl/dram_port_arbiter.sv
// Round-robin arbiter serialising per-core load/store requests onto one synchronous RAM port.
// Optional busy-cycle performance counter enabled by defining ARB_PERF_EN.
module dram_port_arbiter #(
  parameter int N_CORES = 4,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16
) (
  input  logic                clk,
  input  logic                controlRST,
  dram_port_arbiter_if.slave  bus,
  output logic                busy,
  output logic [23:0]         busy_cycles
);
  localparam int RR_W = $clog2(N_CORES);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

  state_t              state_reg;
  logic [RR_W-1:0]     rr_reg;
  logic [RR_W-1:0]     win_reg;
  logic                we_reg;
  logic [N_CORES-1:0]  ack_reg;
  logic [ADDR_W-1:0]   mem_addr_reg;
  logic [DATA_W-1:0]   mem_wdata_reg;
  logic                mem_wren_reg;
  logic                busy_reg;

  logic [ADDR_W-1:0]   addr_arr  [N_CORES];
  logic [DATA_W-1:0]   wdata_arr [N_CORES];

  genvar gi;
  generate
    for (gi = 0; gi < N_CORES; gi++) begin : g_unpack
      assign addr_arr[gi]  = bus.addr[gi*ADDR_W +: ADDR_W];
      assign wdata_arr[gi] = bus.wdata[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // First requesting core found when scanning upward from the round-robin pointer.
  logic            grant_valid;
  logic [RR_W-1:0] grant_id;
  logic [RR_W-1:0] scan_idx;

  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    scan_idx    = '0;
    for (int off = 0; off < N_CORES; off++) begin
      scan_idx = rr_reg + RR_W'(off);
      if (!grant_valid && bus.req[scan_idx]) begin
        grant_valid = 1'b1;
        grant_id    = scan_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (controlRST) begin
      state_reg     <= IDLE;
      rr_reg        <= '0;
      win_reg       <= '0;
      we_reg        <= 1'b0;
      ack_reg       <= '0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      mem_wren_reg  <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      ack_reg      <= '0;
      mem_wren_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          // The RAM bus is loaded here so it is already valid throughout ISSUE.
          if (grant_valid) begin
            win_reg       <= grant_id;
            we_reg        <= bus.we[grant_id];
            mem_addr_reg  <= addr_arr[grant_id];
            mem_wdata_reg <= wdata_arr[grant_id];
            mem_wren_reg  <= bus.we[grant_id];
            busy_reg      <= 1'b1;
            state_reg     <= ISSUE;
          end
        end
        ISSUE: begin
          ack_reg[win_reg] <= 1'b1;
          state_reg        <= CAPTURE;
        end
        CAPTURE: begin
          rr_reg    <= win_reg + RR_W'(1);
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // RAM read data only arrives during CAPTURE, so it is steered straight through while ack is high.
  assign bus.rdata     = (|ack_reg && !we_reg) ? bus.mem_q : '0;
  assign bus.ack       = ack_reg;
  assign bus.mem_addr  = mem_addr_reg;
  assign bus.mem_wdata = mem_wdata_reg;
  assign bus.mem_wren  = mem_wren_reg;
  assign busy          = busy_reg;

`ifdef ARB_PERF_EN
  logic [23:0] busy_cycles_reg;

  always_ff @(posedge clk) begin
    if (controlRST) begin
      busy_cycles_reg <= '0;
    end else if (busy_reg && busy_cycles_reg != 24'hFFFFFF) begin
      busy_cycles_reg <= busy_cycles_reg + 24'd1;
    end
  end

  assign busy_cycles = busy_cycles_reg;
`else
  assign busy_cycles = '0;
`endif
endmodule

// File: tb/tb_dram_port_arbiter.sv
// Directed testbench for dram_port_arbiter with a small synchronous RAM model.
module tb_dram_port_arbiter;
  logic        clk = 1'b0;
  logic        controlRST;
  logic        busy;
  logic [23:0] busy_cycles;
  int          checks = 0;
  int          errors = 0;

  dram_port_arbiter_if bus ();

  dram_port_arbiter dut (
    .clk         (clk),
    .controlRST  (controlRST),
    .bus         (bus.slave),
    .busy        (busy),
    .busy_cycles (busy_cycles)
  );

  always #5 clk = ~clk;

  // RAM model: registered address, one-cycle read latency; bench preload port for setup.
  logic [15:0] ram [0:255];
  logic        pre_en = 1'b0;
  logic [7:0]  pre_addr = '0;
  logic [15:0] pre_data = '0;

  always @(posedge clk) begin
    if (bus.mem_wren) ram[bus.mem_addr[7:0]] <= bus.mem_wdata;
    else if (pre_en)  ram[pre_addr] <= pre_data;
    bus.mem_q <= ram[bus.mem_addr[7:0]];
  end

  task automatic preload(input logic [7:0] a, input logic [15:0] d);
    pre_addr = a; pre_data = d; pre_en = 1'b1;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  task automatic set_core(input int i, input logic w, input logic [15:0] a, input logic [15:0] d);
    bus.we[i] = w;
    bus.addr[i*16 +: 16] = a;
    bus.wdata[i*16 +: 16] = d;
  endtask

  task automatic clear_inputs();
    bus.req = '0; bus.we = '0; bus.addr = '0; bus.wdata = '0;
  endtask

  task automatic do_reset();
    controlRST = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    controlRST = 1'b0;
  endtask

  // Steps negedges until an ack appears or the budget runs out (ack returned as 0 on timeout).
  task automatic wait_ack(input int max_cyc, output int cyc, output logic [3:0] a, output logic [15:0] rd);
    cyc = 0; a = '0; rd = '0;
    while (cyc < max_cyc) begin
      @(negedge clk);
      cyc++;
      if (bus.ack !== 4'b0000) begin
        a = bus.ack; rd = bus.rdata;
        break;
      end
    end
  endtask

  task automatic test_reset();
    controlRST = 1'b1;
    clear_inputs();
    @(negedge clk);
    preload(8'h10, 16'hBEEF);
    for (int i = 0; i < 4; i++) preload(8'(8'h20 + i), 16'(16'hA000 + i));
    preload(8'h30, 16'h0C0C);
    checks++; if (bus.ack !== 4'b0)       begin errors++; $display("FAIL reset_ack: got %b expected 0000", bus.ack); end
    checks++; if (bus.rdata !== 16'h0)    begin errors++; $display("FAIL reset_rdata: got %h expected 0000", bus.rdata); end
    checks++; if (bus.mem_addr !== 16'h0) begin errors++; $display("FAIL reset_mem_addr: got %h expected 0000", bus.mem_addr); end
    checks++; if (bus.mem_wdata !== 16'h0) begin errors++; $display("FAIL reset_mem_wdata: got %h expected 0000", bus.mem_wdata); end
    checks++; if (bus.mem_wren !== 1'b0)  begin errors++; $display("FAIL reset_mem_wren: got %b expected 0", bus.mem_wren); end
    checks++; if (busy !== 1'b0)          begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (busy_cycles !== 24'h0)  begin errors++; $display("FAIL reset_busy_cycles: got %h expected 000000", busy_cycles); end
    controlRST = 1'b0;
    $display("reset: outputs checked");
  endtask

  task automatic test_single_read();
    int cyc; logic [3:0] a; logic [15:0] rd;
    set_core(0, 1'b0, 16'h0010, 16'h0000);
    bus.req = 4'b0001;
    @(negedge clk);
    checks++; if (busy !== 1'b1)           begin errors++; $display("FAIL sr_issue_busy: got %b expected 1", busy); end
    checks++; if (bus.ack !== 4'b0)        begin errors++; $display("FAIL sr_issue_ack: got %b expected 0000", bus.ack); end
    checks++; if (bus.mem_addr !== 16'h0010) begin errors++; $display("FAIL sr_issue_addr: got %h expected 0010", bus.mem_addr); end
    wait_ack(4, cyc, a, rd);
    checks++; if (a !== 4'b0001)  begin errors++; $display("FAIL sr_ack: got %b expected 0001", a); end
    checks++; if (rd !== 16'hBEEF) begin errors++; $display("FAIL sr_rdata: got %h expected beef", rd); end
    checks++; if (cyc !== 1)      begin errors++; $display("FAIL sr_latency: got %0d expected 1 after issue", cyc); end
    checks++; if (busy !== 1'b1)  begin errors++; $display("FAIL sr_capture_busy: got %b expected 1", busy); end
    bus.req = 4'b0000;
    @(negedge clk);
    checks++; if (bus.ack !== 4'b0 || bus.rdata !== 16'h0 || busy !== 1'b0) begin
      errors++; $display("FAIL sr_idle: got ack=%b rdata=%h busy=%b expected 0000/0000/0", bus.ack, bus.rdata, busy);
    end
    $display("single_read: core0 addr=0010 ack=%b rdata=%h", a, rd);
  endtask

  task automatic test_write_read();
    int cyc; logic [3:0] a; logic [15:0] rd;
    set_core(2, 1'b1, 16'h0042, 16'h1234);
    bus.req = 4'b0100;
    @(negedge clk);
    checks++; if (bus.mem_wren !== 1'b1 || bus.mem_addr !== 16'h0042 || bus.mem_wdata !== 16'h1234) begin
      errors++; $display("FAIL wr_issue: got wren=%b addr=%h data=%h expected 1/0042/1234", bus.mem_wren, bus.mem_addr, bus.mem_wdata);
    end
    @(negedge clk);
    checks++; if (bus.mem_wren !== 1'b0) begin errors++; $display("FAIL wr_wren_once: got %b expected 0", bus.mem_wren); end
    checks++; if (bus.ack !== 4'b0100)  begin errors++; $display("FAIL wr_ack: got %b expected 0100", bus.ack); end
    checks++; if (bus.rdata !== 16'h0)  begin errors++; $display("FAIL wr_rdata: got %h expected 0000", bus.rdata); end
    $display("write: core2 addr=0042 data=1234 ack=%b", bus.ack);
    set_core(2, 1'b0, 16'h0042, 16'h0000);
    wait_ack(6, cyc, a, rd);
    checks++; if (a !== 4'b0100)   begin errors++; $display("FAIL rd_ack: got %b expected 0100", a); end
    checks++; if (rd !== 16'h1234) begin errors++; $display("FAIL rd_rdata: got %h expected 1234", rd); end
    checks++; if (cyc !== 3)       begin errors++; $display("FAIL rd_latency: got %0d expected 3", cyc); end
    bus.req = 4'b0000;
    @(negedge clk);
    $display("read: core2 addr=0042 ack=%b rdata=%h", a, rd);
  endtask

  task automatic test_contention();
    int cyc; logic [3:0] a; logic [15:0] rd;
    do_reset();
    for (int i = 0; i < 4; i++) set_core(i, 1'b0, 16'(16'h0020 + i), 16'h0000);
    bus.req = 4'b1111;
    for (int t = 0; t < 8; t++) begin
      logic [3:0] exp_a;
      exp_a = 4'b0001 << (t % 4);
      wait_ack(6, cyc, a, rd);
      checks++; if (a !== exp_a) begin errors++; $display("FAIL cont_ack[%0d]: got %b expected %b", t, a, exp_a); end
      checks++; if (rd !== 16'(16'hA000 + t % 4)) begin errors++; $display("FAIL cont_rdata[%0d]: got %h expected %h", t, rd, 16'(16'hA000 + t % 4)); end
      checks++; if (cyc !== ((t == 0) ? 2 : 3)) begin errors++; $display("FAIL cont_latency[%0d]: got %0d expected %0d", t, cyc, (t == 0) ? 2 : 3); end
      $display("contention: txn %0d ack=%b rdata=%h after %0d cycles", t, a, rd, cyc);
    end
  endtask

  task automatic test_pointer_wrap();
    int cyc; logic [3:0] a; logic [15:0] rd;
    // Entered right at core 3's ack, so the pointer has just wrapped to 0.
    bus.req = 4'b1001;
    wait_ack(6, cyc, a, rd);
    checks++; if (a !== 4'b0001) begin errors++; $display("FAIL wrap_first: got %b expected 0001", a); end
    $display("wrap: first grant ack=%b", a);
    wait_ack(6, cyc, a, rd);
    checks++; if (a !== 4'b1000) begin errors++; $display("FAIL wrap_second: got %b expected 1000", a); end
    checks++; if (rd !== 16'hA003) begin errors++; $display("FAIL wrap_rdata: got %h expected a003", rd); end
    $display("wrap: second grant ack=%b rdata=%h", a, rd);
    bus.req = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_reset_midop();
    int cyc; logic [3:0] a; logic [15:0] rd;
    // Serve core 2 first so the pointer sits at 3 before the aborted transaction.
    set_core(2, 1'b0, 16'h0030, 16'h0000);
    bus.req = 4'b0100;
    wait_ack(6, cyc, a, rd);
    checks++; if (a !== 4'b0100 || rd !== 16'h0C0C) begin errors++; $display("FAIL mid_pre: got ack=%b rdata=%h expected 0100/0c0c", a, rd); end
    bus.req = 4'b0000;
    @(negedge clk);
    set_core(1, 1'b1, 16'h0077, 16'h5555);
    bus.req = 4'b0010;
    @(negedge clk);
    checks++; if (bus.mem_wren !== 1'b1) begin errors++; $display("FAIL mid_issue_wren: got %b expected 1", bus.mem_wren); end
    controlRST = 1'b1;
    @(negedge clk);
    checks++; if (bus.ack !== 4'b0)     begin errors++; $display("FAIL mid_no_ack: got %b expected 0000", bus.ack); end
    checks++; if (bus.mem_wren !== 1'b0) begin errors++; $display("FAIL mid_wren: got %b expected 0", bus.mem_wren); end
    checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL mid_idle: busy got %b expected 0", busy); end
    controlRST = 1'b0;
    set_core(1, 1'b0, 16'h0021, 16'h0000);
    set_core(3, 1'b0, 16'h0023, 16'h0000);
    bus.req = 4'b1010;
    wait_ack(6, cyc, a, rd);
    checks++; if (a !== 4'b0010)  begin errors++; $display("FAIL mid_rr_reset: got %b expected 0010", a); end
    checks++; if (rd !== 16'hA001) begin errors++; $display("FAIL mid_rr_rdata: got %h expected a001", rd); end
    $display("reset_midop: after reset ack=%b rdata=%h", a, rd);
    bus.req = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_perf();
    int cyc; logic [3:0] a; logic [15:0] rd;
    logic [23:0] exp_cnt;
    int stray;
`ifdef ARB_PERF_EN
    exp_cnt = 24'd8;
`else
    exp_cnt = 24'd0;
`endif
    do_reset();
    for (int i = 0; i < 4; i++) set_core(i, 1'b0, 16'(16'h0020 + i), 16'h0000);
    bus.req = 4'b1111;
    for (int t = 0; t < 4; t++) begin
      wait_ack(6, cyc, a, rd);
      checks++; if (a !== (4'b0001 << t)) begin errors++; $display("FAIL perf_ack[%0d]: got %b expected %b", t, a, 4'b0001 << t); end
    end
    bus.req = 4'b0000;
    @(negedge clk);
    checks++; if (busy_cycles !== exp_cnt) begin errors++; $display("FAIL perf_count: got %0d expected %0d", busy_cycles, exp_cnt); end
    stray = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.ack !== 4'b0) stray++;
    end
    checks++; if (stray !== 0) begin errors++; $display("FAIL perf_idle_ack: got %0d stray acks expected 0", stray); end
    checks++; if (busy_cycles !== exp_cnt) begin errors++; $display("FAIL perf_hold: got %0d expected %0d", busy_cycles, exp_cnt); end
    $display("perf: busy_cycles=%0d", busy_cycles);
  endtask

  initial begin
    controlRST = 1'b1;
    clear_inputs();
    @(negedge clk);
    test_reset();
    test_single_read();
    test_write_read();
    test_contention();
    test_pointer_wrap();
    test_reset_midop();
    test_perf();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
